// File: rtl/arbiter_burst.sv
// arbiter_burst: N-channel bus arbiter with run-time round-robin / fixed
// priority selection, a per-grant burst limit and per-channel lock.
// One owner at a time is granted the shared downstream interface.
module arbiter_burst #(
  parameter int N        = 8,
  parameter int MAXBURST = 0,
  parameter int IW       = $clog2(N)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          ifrdy,
  input  logic          rr_en,
  input  logic [N-1:0]  req,
  input  logic [N-1:0]  lock,
  output logic [N-1:0]  sel,
  output logic [N-1:0]  rdy,
  output logic [IW-1:0] gid,
  output logic          gvalid
);

  // Burst counter is at least one bit wide, even with an unlimited burst.
  localparam int            CW       = (MAXBURST > 0) ? $clog2(MAXBURST + 1) : 1;
  localparam logic [CW-1:0] CNT_LIM  = CW'((MAXBURST > 0) ? (MAXBURST - 1) : 0);
  localparam logic [CW-1:0] CNT_MAX  = {CW{1'b1}};
  localparam logic          BURST_EN = (MAXBURST != 0);

  logic [N-1:0]  sel_r;
  logic [IW-1:0] gid_r;
  logic          gvalid_r;
  logic [IW-1:0] ptr_r;
  logic [CW-1:0] cnt_r;

  logic          found_s;
  logic [IW-1:0] pick_s;
  logic [IW-1:0] ptr_nxt_s;
  logic          beat_s;
  logic          expire_s;
  logic          release_s;

  // First requester found scanning from 'start' (wrapping) in round-robin
  // mode, or from index 0 in fixed-priority mode. MSB flags a hit.
  function automatic logic [IW:0] find_req(input logic [N-1:0]  r,
                                           input logic [IW-1:0] start,
                                           input logic          rr);
    logic          found;
    logic [IW-1:0] idx;
    logic [IW-1:0] best;
    found = 1'b0;
    best  = {IW{1'b0}};
    for (int k = 0; k < N; k++) begin
      idx   = rr ? IW'((int'(start) + k) % N) : IW'(k);
      best  = (!found && r[idx]) ? idx : best;
      found = found | r[idx];
    end
    return {found, best};
  endfunction

  // One-hot decode of a channel index.
  function automatic logic [N-1:0] onehot(input logic [IW-1:0] i);
    logic [N-1:0] v;
    v    = {N{1'b0}};
    v[i] = 1'b1;
    return v;
  endfunction

  // Arbitration decision: candidate winner, beat detection and release.
  always_comb begin
    {found_s, pick_s} = find_req(req, ptr_r, rr_en);
    ptr_nxt_s = (pick_s == IW'(N - 1)) ? {IW{1'b0}} : (pick_s + IW'(1));
    beat_s    = gvalid_r & ifrdy & req[gid_r];
    // A counter pushed past the limit while locked expires on the next
    // unlocked beat, so the limit test is "reached or beyond".
    expire_s  = BURST_EN & ~lock[gid_r] & beat_s &
                ((cnt_r == CNT_LIM) | (cnt_r > CNT_LIM));
    release_s = ~gvalid_r | ~req[gid_r] | expire_s;
  end

  // Grant state: reset, stall hold, re-arbitrate on release, count beats.
  always_ff @(posedge clk) begin
    if (reset) begin
      sel_r    <= {N{1'b0}};
      gid_r    <= {IW{1'b0}};
      gvalid_r <= 1'b0;
      ptr_r    <= {IW{1'b0}};
      cnt_r    <= {CW{1'b0}};
    end else if (!ifrdy) begin
      // Stalled: a grant is never revoked while the interface is not ready.
      sel_r    <= sel_r;
      gid_r    <= gid_r;
      gvalid_r <= gvalid_r;
      ptr_r    <= ptr_r;
      cnt_r    <= cnt_r;
    end else if (release_s) begin
      if (found_s) begin
        sel_r    <= onehot(pick_s);
        gid_r    <= pick_s;
        gvalid_r <= 1'b1;
        ptr_r    <= ptr_nxt_s;
        cnt_r    <= {CW{1'b0}};
      end else begin
        // Idle: gid and ptr keep their last values.
        sel_r    <= {N{1'b0}};
        gvalid_r <= 1'b0;
        cnt_r    <= {CW{1'b0}};
      end
    end else if (beat_s && (cnt_r != CNT_MAX)) begin
      // Saturate rather than wrap so a long locked burst still expires.
      cnt_r <= cnt_r + CW'(1);
    end else begin
      cnt_r <= cnt_r;
    end
  end

  assign sel    = sel_r;
  assign gid    = gid_r;
  assign gvalid = gvalid_r;
  assign rdy    = sel_r & {N{ifrdy}};

endmodule

// File: tb/tb_arbiter_burst.sv
// Directed bench for arbiter_burst: three instances (unlimited, 4-beat and
// 2-beat bursts) share one stimulus; each step checks the instance under test.
module tb_arbiter_burst;

  logic       clk = 1'b0;
  logic       reset;
  logic       ifrdy;
  logic       rr_en;
  logic [7:0] req;
  logic [7:0] lock;

  logic [7:0] sel_o  [3];
  logic [7:0] rdy_o  [3];
  logic [2:0] gid_o  [3];
  logic       gv_o   [3];

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [7:0] sel;
    logic [2:0] gid;
    logic       gv;
    logic [7:0] rdy;
    string      tag;
  } exp_t;

  exp_t sbq[$];

  // Burst-limit scenario: expected owner per edge and interface readiness.
  localparam logic [7:0] B_SEL [15] = '{8'h02, 8'h02, 8'h02, 8'h02, 8'h40, 8'h40, 8'h40, 8'h40,
                                       8'h02, 8'h02, 8'h02, 8'h02, 8'h02, 8'h02, 8'h40};
  localparam logic       B_RDY [15] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1,
                                       1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};

  arbiter_burst #(.N(8), .MAXBURST(0)) u_unl (
    .clk(clk), .reset(reset), .ifrdy(ifrdy), .rr_en(rr_en), .req(req), .lock(lock),
    .sel(sel_o[0]), .rdy(rdy_o[0]), .gid(gid_o[0]), .gvalid(gv_o[0]));

  arbiter_burst #(.N(8), .MAXBURST(4)) u_b4 (
    .clk(clk), .reset(reset), .ifrdy(ifrdy), .rr_en(rr_en), .req(req), .lock(lock),
    .sel(sel_o[1]), .rdy(rdy_o[1]), .gid(gid_o[1]), .gvalid(gv_o[1]));

  arbiter_burst #(.N(8), .MAXBURST(2)) u_b2 (
    .clk(clk), .reset(reset), .ifrdy(ifrdy), .rr_en(rr_en), .req(req), .lock(lock),
    .sel(sel_o[2]), .rdy(rdy_o[2]), .gid(gid_o[2]), .gvalid(gv_o[2]));

  // Free-running clock, 10 time units per period.
  always #5 clk = ~clk;

  task automatic chk(input string tag, input string field, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s.%s observed=%0h expected=%0h", tag, field, obs, exp);
    end
  endtask

  // Drive one cycle of inputs, queue the expected post-edge state, then
  // pop it after the edge and compare against instance 'which'.
  task automatic step(input logic [7:0] r, input logic [7:0] l, input logic rr,
                      input logic rdy_in, input logic rst, input int which,
                      input logic [7:0] es, input logic [2:0] eg, input string tag);
    exp_t e;
    req   = r;
    lock  = l;
    rr_en = rr;
    ifrdy = rdy_in;
    reset = rst;
    sbq.push_back('{sel: es, gid: eg, gv: (es != 8'h00), rdy: (es & {8{rdy_in}}), tag: tag});
    @(posedge clk);
    #1;
    e = sbq.pop_front();
    chk(e.tag, "sel",    32'(sel_o[which]), 32'(e.sel));
    chk(e.tag, "gid",    32'(gid_o[which]), 32'(e.gid));
    chk(e.tag, "gvalid", 32'(gv_o[which]),  32'(e.gv));
    chk(e.tag, "rdy",    32'(rdy_o[which]), 32'(e.rdy));
  endtask

  initial begin
    req = 8'h00; lock = 8'h00; rr_en = 1'b1; ifrdy = 1'b1; reset = 1'b1;

    // Reset state on every instance.
    step(8'h00, 8'h00, 1'b1, 1'b1, 1'b1, 0, 8'h00, 3'd0, "rst");
    for (int d = 1; d < 3; d++) begin
      chk("rst_all", "sel",    32'(sel_o[d]), 32'h0);
      chk("rst_all", "gvalid", 32'(gv_o[d]),  32'h0);
    end

    // Round-robin rotation, unlimited burst.
    step(8'h28, 8'h00, 1'b1, 1'b1, 1'b0, 0, 8'h08, 3'd3, "rr_first");
    for (int i = 0; i < 5; i++) step(8'h28, 8'h00, 1'b1, 1'b1, 1'b0, 0, 8'h08, 3'd3, "rr_hold");
    step(8'hA5, 8'h00, 1'b1, 1'b1, 1'b0, 0, 8'h20, 3'd5, "rr_to5");
    step(8'h85, 8'h00, 1'b1, 1'b1, 1'b0, 0, 8'h80, 3'd7, "rr_to7");
    step(8'h05, 8'h00, 1'b1, 1'b1, 1'b0, 0, 8'h01, 3'd0, "rr_to0");
    step(8'h04, 8'h00, 1'b1, 1'b1, 1'b0, 0, 8'h04, 3'd2, "rr_to2");

    // Stall: grant held while ifrdy=0 even though the owner drops req.
    step(8'h00, 8'h00, 1'b1, 1'b1, 1'b1, 0, 8'h00, 3'd0, "st_rst");
    step(8'h20, 8'h00, 1'b1, 1'b1, 1'b0, 0, 8'h20, 3'd5, "st_grant");
    step(8'h02, 8'h00, 1'b1, 1'b0, 1'b0, 0, 8'h20, 3'd5, "st_hold_a");
    step(8'h02, 8'h00, 1'b1, 1'b0, 1'b0, 0, 8'h20, 3'd5, "st_hold_b");
    step(8'h02, 8'h00, 1'b1, 1'b1, 1'b0, 0, 8'h02, 3'd1, "st_next");
    step(8'h00, 8'h00, 1'b1, 1'b0, 1'b0, 0, 8'h02, 3'd1, "st_hold_c");
    step(8'h00, 8'h00, 1'b1, 1'b1, 1'b0, 0, 8'h00, 3'd1, "st_idle");

    // Burst limit of 4 beats, alternating 1 and 6, with stalls inserted.
    step(8'h00, 8'h00, 1'b1, 1'b1, 1'b1, 1, 8'h00, 3'd0, "bl_rst");
    for (int i = 0; i < 15; i++)
      step(8'h42, 8'h00, 1'b1, B_RDY[i], 1'b0, 1, B_SEL[i],
           (B_SEL[i] == 8'h02) ? 3'd1 : 3'd6, "bl_beat");

    // Lock holds channel 1 for 10 beats; counter saturates; drop releases.
    step(8'h00, 8'h00, 1'b1, 1'b1, 1'b1, 1, 8'h00, 3'd0, "lk_rst");
    for (int i = 0; i < 11; i++) step(8'h42, 8'h02, 1'b1, 1'b1, 1'b0, 1, 8'h02, 3'd1, "lk_hold");
    step(8'h42, 8'h00, 1'b1, 1'b1, 1'b0, 1, 8'h40, 3'd6, "lk_release");

    // Fixed priority with 2-beat bursts, then switch to round-robin.
    step(8'h00, 8'h00, 1'b0, 1'b1, 1'b1, 2, 8'h00, 3'd0, "fp_rst");
    for (int i = 0; i < 6; i++) step(8'hA4, 8'h00, 1'b0, 1'b1, 1'b0, 2, 8'h04, 3'd2, "fp_hold");
    step(8'hA4, 8'h00, 1'b1, 1'b1, 1'b0, 2, 8'h20, 3'd5, "sw_5a");
    step(8'hA4, 8'h00, 1'b1, 1'b1, 1'b0, 2, 8'h20, 3'd5, "sw_5b");
    step(8'hA4, 8'h00, 1'b1, 1'b1, 1'b0, 2, 8'h80, 3'd7, "sw_7a");
    step(8'hA4, 8'h00, 1'b1, 1'b1, 1'b0, 2, 8'h80, 3'd7, "sw_7b");
    step(8'hA4, 8'h00, 1'b1, 1'b1, 1'b0, 2, 8'h04, 3'd2, "sw_2");

    // Reset mid-burst (with ifrdy=0, reset wins), search restarts at 0.
    step(8'h00, 8'h00, 1'b1, 1'b1, 1'b1, 1, 8'h00, 3'd0, "mb_rst0");
    step(8'h40, 8'h00, 1'b1, 1'b1, 1'b0, 1, 8'h40, 3'd6, "mb_grant");
    step(8'h40, 8'h00, 1'b1, 1'b1, 1'b0, 1, 8'h40, 3'd6, "mb_cnt1");
    step(8'h40, 8'h00, 1'b1, 1'b0, 1'b1, 1, 8'h00, 3'd0, "mb_rst");
    step(8'hC1, 8'h00, 1'b1, 1'b1, 1'b0, 1, 8'h01, 3'd0, "mb_first");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
